pc_fetch_sequencer: RTL and testbench

//  Generates the fetch program counter and the per-stage nop (flush) request consumed by the PC pipeline registers.

---
 rtl/pc_fetch_pkg.sv | 21 ++
 rtl/pc_fetch_sequencer_flush_counter.sv | 25 ++
 rtl/pc_fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the IF-stage PC sequencer.
// State enum, PC increment and default reset/trap vectors.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } state_t;

  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

  function automatic logic [31:0] clr_bit0(
    input logic [31:0] a
  );
    return a & ~32'h1;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_flush_counter.sv
// Flush cycle counter: load, decrement-with-enable, zero flag.
// Ports: clk, rst, load, load_val[2:0], dec, cnt[2:0], zero.
module flush_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic [2:0] cnt,
  output logic       zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 3'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign zero = (cnt == 3'd0);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch PC generator with redirect, stall hold and timed flush.
// Ports: clk, rst (sync, high), stall, branch_taken/branch_target,
// jump/jump_target in; pc, nop, redirected, misaligned out.
// Optional: PC_ALIGN_CHECK_EN traps on targets with bit1 set.
module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int          FLUSH_DEPTH  = 2,
  parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic        nop,
  output logic        redirected,
  output logic        misaligned
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

  state_t      state;
  state_t      state_n;
  logic [31:0] pc_n;
  logic        nop_n;
  logic        red_n;
  logic        mis_n;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] redir_pc;
  logic        redir_mis;

  logic        cnt_load;
  logic        cnt_dec;
  logic [2:0]  cnt;
  logic        cnt_zero;

  // EX branch is older than the ID jump, so it wins.
  assign redirect = branch_taken | jump;
  assign target   = branch_taken ? branch_target
                                 : jump_target;

`ifdef PC_ALIGN_CHECK_EN
  always_comb begin
    redir_pc  = clr_bit0(target);
    redir_mis = 1'b0;
    if (target[1]) begin
      redir_pc  = TRAP_VECTOR;
      redir_mis = 1'b1;
    end
  end
`else
  logic unused_trap;
  assign unused_trap = ^TRAP_VECTOR;
  assign redir_pc    = clr_bit0(target);
  assign redir_mis   = 1'b0;
`endif

  flush_counter u_flush_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (FLUSH_LOAD),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    nop_n    = nop;
    red_n    = 1'b0;
    mis_n    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state)
      BOOT: begin
        // Pipeline empty: redirects are ignored.
        state_n = RUN;
        nop_n   = 1'b0;
      end
      RUN: begin
        if (redirect) begin
          state_n  = FLUSH;
          pc_n     = redir_pc;
          nop_n    = 1'b1;
          red_n    = 1'b1;
          mis_n    = redir_mis;
          cnt_load = 1'b1;
        end else begin
          nop_n = 1'b0;
          if (!stall) begin
            pc_n = pc + PC_INCR;
          end
        end
      end
      FLUSH: begin
        if (redirect) begin
          pc_n     = redir_pc;
          nop_n    = 1'b1;
          red_n    = 1'b1;
          mis_n    = redir_mis;
          cnt_load = 1'b1;
        end else if (!stall) begin
          pc_n = pc + PC_INCR;
          if (cnt_zero) begin
            state_n = RUN;
            nop_n   = 1'b0;
          end else begin
            cnt_dec = 1'b1;
            nop_n   = 1'b1;
          end
        end else begin
          nop_n = 1'b1;
        end
      end
      default: begin
        state_n = BOOT;
        nop_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_VECTOR;
      nop        <= 1'b1;
      redirected <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      nop        <= nop_n;
      redirected <= red_n;
      misaligned <= mis_n;
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer.
// Directed spec scenarios then random traffic vs. a reference model.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] TV    = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic        nop;
  logic        redirected;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  bit          m_boot;
  int          m_left;
  logic        m_nop;
  logic        m_red;
  logic        m_mis;

  pc_fetch_sequencer #(
    .RESET_VECTOR (RV),
    .FLUSH_DEPTH  (DEPTH),
    .TRAP_VECTOR  (TV)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc            (pc),
    .nop           (nop),
    .redirected    (redirected),
    .misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // m_left counts the non-stalled cycles that still emit nop.
  task automatic model(input bit r, input bit s,
                       input bit bt, input logic [31:0] bto,
                       input bit j, input logic [31:0] jto);
    logic [31:0] t;
    m_red = 1'b0;
    m_mis = 1'b0;
    if (r) begin
      m_pc   = RV;
      m_boot = 1;
      m_left = 0;
      m_nop  = 1'b1;
    end else if (m_boot) begin
      m_boot = 0;
      m_nop  = 1'b0;
    end else if (bt || j) begin
      t      = bt ? bto : jto;
      m_red  = 1'b1;
      m_left = DEPTH;
      m_nop  = 1'b1;
      m_pc   = {t[31:1], 1'b0};
`ifdef PC_ALIGN_CHECK_EN
      if (t[1]) begin
        m_pc  = TV;
        m_mis = 1'b1;
      end
`endif
    end else begin
      if (!s) begin
        m_pc = m_pc + 32'd4;
        if (m_left > 0) m_left--;
      end
      m_nop = (m_left > 0);
    end
  endtask

  task automatic cyc(input bit r, input bit s,
                     input bit bt, input logic [31:0] bto,
                     input bit j, input logic [31:0] jto);
    rst           = r;
    stall         = s;
    branch_taken  = bt;
    branch_target = bto;
    jump          = j;
    jump_target   = jto;
    @(posedge clk);
    model(r, s, bt, bto, j, jto);
    #1;
    chk("pc", pc, m_pc);
    chk("nop", 32'(nop), 32'(m_nop));
    chk("redirected", 32'(redirected), 32'(m_red));
    chk("misaligned", 32'(misaligned), 32'(m_mis));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic jmp(input logic [31:0] t);
    cyc(0, 0, 0, 0, 1, t);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0;
    m_pc = RV; m_boot = 1; m_left = 0;
    m_nop = 1'b1; m_red = 1'b0; m_mis = 1'b0;

    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("reset_pc", pc, RV);
    chk("reset_nop", 32'(nop), 32'd1);

    idle(1);
    chk("boot_exit_pc", pc, 32'h0);
    chk("boot_exit_nop", 32'(nop), 32'd0);
    idle(16);
    chk("seq_pc", pc, 32'h40);

    cyc(0, 0, 1, 32'h200, 0, 0);
    chk("branch_pc", pc, 32'h200);
    idle(1);
    chk("flush_pc1", pc, 32'h204);
    chk("flush_nop1", 32'(nop), 32'd1);
    idle(1);
    chk("flush_pc2", pc, 32'h208);
    chk("flush_nop2", 32'(nop), 32'd0);

    cyc(0, 0, 1, 32'h300, 1, 32'h500);
    chk("prio_pc", pc, 32'h300);
    jmp(32'h600);
    idle(3);

    jmp(32'h8);
    idle(2);
    chk("pre_stall_pc", pc, 32'h10);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
    chk("stall_pc", pc, 32'h10);
    cyc(0, 1, 0, 0, 1, 32'h80);
    chk("stall_jump_pc", pc, 32'h80);
    cyc(0, 1, 0, 0, 0, 0);
    idle(2);

    jmp(32'hFFFF_FFF4);
    idle(3);
    chk("wrap_pc", pc, 32'h0);

    jmp(32'h400);
    cyc(1, 0, 0, 0, 0, 0);
    chk("midflush_rst_pc", pc, RV);
    cyc(0, 0, 0, 0, 1, 32'h700);
    idle(2);

    jmp(32'h102);
    idle(3);
    jmp(32'h101);
    chk("bit0_clear_pc", pc, 32'h100);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 10, $urandom(),
          $urandom_range(0, 99) < 10, $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
